// File: rtl/net_rx.sv
// net_rx: RGMII receive path, rxclk domain.
// Preamble/SFD detect, FCS strip, CRC/length/RX_ER check, frame counters.
module net_rx #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             rxclk,
  input  logic             rst_n,
  input  logic [3:0]       rxd_r,
  input  logic [3:0]       rxd_f,
  input  logic             rxctl_r,
  input  logic             rxctl_f,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_first,
  output logic             m_last,
  output logic             m_good,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_bad
);

  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(5);
  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] RESIDUE = 32'hC704DD7B;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    DATA,
    DROP
  } state_t;

  state_t state, state_n;

  logic       dv;
  logic       er;
  logic [7:0] rx_byte;

  assign dv      = rxctl_r;
  assign er      = rxctl_r ^ rxctl_f;
  assign rx_byte = {rxd_f, rxd_r};

  logic             armed;
  logic [LEN_W-1:0] len;
  logic [31:0]      crc;
  logic             er_seen;
  logic [7:0]       pipe [5];

  logic shift;
  logic frame_end;
  logic overflow;
  logic full;
  logic crc_ok;
  logic good;
  logic emit;
  logic ok_inc;
  logic bad_inc;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    return r;
  endfunction

  // The reflected register is compared in MSB-first bit order
  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = v[31-i];
    return r;
  endfunction

  // Next state and per-cycle frame events
  always_comb begin
    state_n   = state;
    shift     = 1'b0;
    frame_end = 1'b0;
    overflow  = 1'b0;
    unique case (state)
      IDLE: begin
        if (dv && armed && rx_byte == 8'h55)
          state_n = PRE;
      end
      PRE: begin
        if (!dv)
          state_n = IDLE;
        else if (rx_byte == 8'hD5)
          state_n = DATA;
        else if (rx_byte != 8'h55)
          state_n = IDLE;
      end
      DATA: begin
        if (!dv) begin
          frame_end = 1'b1;
          state_n   = IDLE;
        end else if (len == LEN_MAX) begin
          overflow = 1'b1;
          state_n  = DROP;
        end else begin
          shift = 1'b1;
        end
      end
      DROP: begin
        if (!dv)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Head of pipe is real frame data only once 5 bytes are in
  assign full    = len >= LEN_FULL;
  assign crc_ok  = rev32(crc) == RESIDUE;
  assign good    = crc_ok && len >= LEN_MIN && !er_seen;
  assign emit    = full && (shift || frame_end || overflow);
  assign ok_inc  = frame_end && full && good;
  assign bad_inc = (frame_end && !(full && good)) || overflow;

  // State register
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_n;
  end

  // After reset, ignore traffic until the line has been idle once
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n)
      armed <= 1'b0;
    else if (!dv)
      armed <= 1'b1;
  end

  // Length, CRC and error accumulation over bytes after SFD
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      len     <= '0;
      crc     <= '1;
      er_seen <= 1'b0;
    end else if (state == PRE && state_n == DATA) begin
      len     <= '0;
      crc     <= '1;
      er_seen <= 1'b0;
    end else if (state == DATA && dv) begin
      len     <= len + 1'b1;
      crc     <= crc_step(crc, rx_byte);
      er_seen <= er_seen | er;
    end
  end

  // FCS-strip delay line; pipe[0] is the oldest byte
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++)
        pipe[i] <= '0;
    end else if (shift) begin
      for (int i = 0; i < 4; i++)
        pipe[i] <= pipe[i+1];
      pipe[4] <= rx_byte;
    end else if (frame_end || overflow) begin
      for (int i = 0; i < 5; i++)
        pipe[i] <= '0;
    end
  end

  // Registered output stream
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      m_first <= 1'b0;
      m_last  <= 1'b0;
      m_good  <= 1'b0;
    end else begin
      m_data  <= emit ? pipe[0] : 8'h00;
      m_valid <= emit;
      m_first <= emit && len == LEN_FULL;
      m_last  <= emit && (frame_end || overflow);
      m_good  <= emit && frame_end && good;
    end
  end

  // Saturating frame statistics
  always_ff @(posedge rxclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok  <= '0;
      cnt_bad <= '0;
    end else begin
      if (ok_inc && cnt_ok != {CNT_W{1'b1}})
        cnt_ok <= cnt_ok + 1'b1;
      if (bad_inc && cnt_bad != {CNT_W{1'b1}})
        cnt_bad <= cnt_bad + 1'b1;
    end
  end

endmodule

// File: tb/tb_net_rx.sv
// tb_net_rx: directed and random frames for net_rx.
// Expected beats and counters come from a frame-level model.
module tb_net_rx;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;
  localparam int CNT_W   = 16;

  logic             rxclk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       rxd_r = '0;
  logic [3:0]       rxd_f = '0;
  logic             rxctl_r = 1'b0;
  logic             rxctl_f = 1'b0;
  logic [7:0]       m_data;
  logic             m_valid;
  logic             m_first;
  logic             m_last;
  logic             m_good;
  logic [CNT_W-1:0] cnt_ok;
  logic [CNT_W-1:0] cnt_bad;

  net_rx #(
    .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN),
    .CNT_W  (CNT_W)
  ) dut (
    .rxclk  (rxclk),
    .rst_n  (rst_n),
    .rxd_r  (rxd_r),
    .rxd_f  (rxd_f),
    .rxctl_r(rxctl_r),
    .rxctl_f(rxctl_f),
    .m_data (m_data),
    .m_valid(m_valid),
    .m_first(m_first),
    .m_last (m_last),
    .m_good (m_good),
    .cnt_ok (cnt_ok),
    .cnt_bad(cnt_bad)
  );

  always #4 rxclk = ~rxclk;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_ok   = 0;
  int exp_bad  = 0;

  // beat = {data, first, last, good-at-last}
  logic [10:0] got[$];
  logic [10:0] exp_q[$];

  // Capture every output beat
  always @(negedge rxclk)
    if (m_valid)
      got.push_back({m_data, m_first, m_last, m_good & m_last});

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ethernet FCS value of a byte sequence
  function automatic logic [31:0] fcs_of(input logic [7:0] d[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (d[i]) begin
      c = c ^ {24'h0, d[i]};
      for (int k = 0; k < 8; k++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // n bytes after SFD; last 4 are the FCS (LSB first), optionally corrupted
  task automatic make_frame(input int n, input bit fcs_ok,
                            output logic [7:0] f[$]);
    logic [7:0]  p[$];
    logic [31:0] fcs;
    f = {};
    if (n < 5) begin
      for (int i = 0; i < n; i++)
        f.push_back(8'($urandom));
    end else begin
      for (int i = 0; i < n - 4; i++)
        p.push_back(8'($urandom));
      fcs = fcs_of(p);
      if (!fcs_ok)
        fcs[$urandom_range(0, 31)] ^= 1'b1;
      f = p;
      for (int i = 0; i < 4; i++)
        f.push_back(fcs[8*i +: 8]);
    end
  endtask

  // Frame-level reference: what the receiver should emit and count
  task automatic model(input logic [7:0] f[$], input bit er);
    int          n;
    int          nb;
    bit          good;
    logic [7:0]  p[$];
    logic [31:0] fcs;
    n = f.size();
    if (n > MAX_LEN) begin
      nb = MAX_LEN - 4;
      for (int i = 0; i < nb; i++)
        exp_q.push_back({f[i], 1'(i == 0), 1'(i == nb - 1), 1'b0});
      exp_bad++;
    end else if (n <= 4) begin
      exp_bad++;
    end else begin
      for (int i = 0; i < n - 4; i++)
        p.push_back(f[i]);
      fcs = {f[n-1], f[n-2], f[n-3], f[n-4]};
      good = (fcs_of(p) == fcs) && n >= MIN_LEN && !er;
      nb = n - 4;
      for (int i = 0; i < nb; i++)
        exp_q.push_back({f[i], 1'(i == 0), 1'(i == nb - 1),
                         1'(good && i == nb - 1)});
      if (good)
        exp_ok++;
      else
        exp_bad++;
    end
  endtask

  task automatic drv(input logic [7:0] b, input logic dv, input logic er);
    rxd_r   = b[3:0];
    rxd_f   = b[7:4];
    rxctl_r = dv;
    rxctl_f = dv ^ er;
    @(posedge rxclk);
    #1;
  endtask

  task automatic send(input logic [7:0] f[$], input int er_at);
    repeat (7) drv(8'h55, 1'b1, 1'b0);
    drv(8'hD5, 1'b1, 1'b0);
    foreach (f[i])
      drv(f[i], 1'b1, 1'(i == er_at));
    drv(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check(input string tag);
    int n;
    repeat (4) drv(8'h00, 1'b0, 1'b0);
    chk({tag, ".beats"}, got.size(), exp_q.size());
    n = got.size() < exp_q.size() ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s.beat%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk({tag, ".cnt_ok"}, 32'(cnt_ok), 32'(exp_ok));
    chk({tag, ".cnt_bad"}, 32'(cnt_bad), 32'(exp_bad));
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];
    logic [7:0] tail[$];
    int         n;
    int         er_at;
    bit         ok;

    repeat (3) @(posedge rxclk);
    #1;
    chk("rst.valid", 32'(m_valid), 0);
    chk("rst.last", 32'(m_last), 0);
    chk("rst.cnt_ok", 32'(cnt_ok), 0);
    chk("rst.cnt_bad", 32'(cnt_bad), 0);
    rst_n = 1'b1;
    repeat (2) drv(8'h00, 1'b0, 1'b0);

    // good 64-byte frame
    make_frame(64, 1'b1, f);
    send(f, -1);
    model(f, 1'b0);
    check("t1");

    // FCS bit flipped
    make_frame(64, 1'b0, f);
    send(f, -1);
    model(f, 1'b0);
    check("t2");

    // RX_ER at byte 20
    make_frame(64, 1'b1, f);
    send(f, 20);
    model(f, 1'b1);
    check("t3");

    // runts
    make_frame(40, 1'b1, f);
    send(f, -1);
    model(f, 1'b0);
    check("t4a");
    make_frame(3, 1'b1, f);
    send(f, -1);
    model(f, 1'b0);
    check("t4b");

    // m_first and m_last together
    make_frame(5, 1'b1, f);
    send(f, -1);
    model(f, 1'b0);
    check("t4c");

    // overlong
    make_frame(1600, 1'b1, f);
    send(f, -1);
    model(f, 1'b0);
    check("t5");

    // random frames
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(1, 140);
      ok = $urandom_range(0, 3) != 0;
      er_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
      make_frame(n, ok, f);
      send(f, er_at);
      model(f, er_at >= 0);
      check($sformatf("rnd%0d", k));
    end

    // back-to-back good frames, one idle cycle apart
    make_frame(64, 1'b1, f);
    make_frame(70, 1'b1, g);
    send(f, -1);
    send(g, -1);
    model(f, 1'b0);
    model(g, 1'b0);
    check("t6a");

    // reset in the middle of a third frame
    repeat (7) drv(8'h55, 1'b1, 1'b0);
    drv(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      drv(8'($urandom), 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6.rst.valid", 32'(m_valid), 0);
    chk("t6.rst.cnt_ok", 32'(cnt_ok), 0);
    chk("t6.rst.cnt_bad", 32'(cnt_bad), 0);
    exp_ok = 0;
    exp_bad = 0;
    got.delete();
    exp_q.delete();
    drv(8'($urandom), 1'b1, 1'b0);
    drv(8'($urandom), 1'b1, 1'b0);
    rst_n = 1'b1;
    // remainder of the third frame contains a fake preamble
    tail = {8'h12, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55,
            8'h55, 8'hD5};
    for (int i = 0; i < 40; i++)
      tail.push_back(8'($urandom));
    foreach (tail[i])
      drv(tail[i], 1'b1, 1'b0);
    drv(8'h00, 1'b0, 1'b0);
    check("t6b");

    // fourth frame after reset
    make_frame(64, 1'b1, f);
    send(f, -1);
    model(f, 1'b0);
    check("t6c");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
